// File: rtl/fir_filter_if.sv
// Sample stream interface for the FIR filter.
// Purpose : bundles the input sample and the filtered output so a source and
//           a filter can be wired together with one connection.
// Signals : x - signed input sample, driven by the source (master)
//           y - signed filtered output, driven by the filter (slave)
// Modports: master - sample source / consumer side (drives x, reads y)
//           slave  - filter side (reads x, drives y)
interface fir_filter_if #(
   parameter int M = 8
);
   logic signed [M-1:0] x;
   logic signed [M-1:0] y;

   modport master (output x, input y);
   modport slave  (input x, output y);
endinterface

// File: rtl/fir_filter.sv
// Direct-form, fully parallel N-tap FIR filter.
// Purpose : multiply-accumulates the newest sample and the N-1 previous
//           samples against fixed signed Q1.(M-1) coefficients, scales the
//           full-precision sum back to M bits (truncating toward minus
//           infinity) and saturates it into a registered output.
// Ports   : clk   - rising-edge clock, one new sample per edge
//           reset - asynchronous active-low reset, clears history and output
//           bus   - fir_filter_if slave: x (sample in), y (filtered out)
module fir_filter #(
   parameter int              N      = 16,
   parameter int              M      = 8,
   parameter logic [N*M-1:0]  COEFFS = {N{M'(8)}}
) (
   input  logic         clk,
   input  logic         reset,
   fir_filter_if.slave  bus
);

   // Full products are 2M bits; summing N of them needs clog2(N) more bits.
   // One extra guard bit covers the (-2^(M-1))^2 corner exactly.
   localparam int ACC_W = 2 * M + $clog2(N) + 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (M - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

   // d[k] holds the sample that arrived k edges before the current x.
   logic signed [M-1:0]     d [1:N-1];
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] scaled;
   logic signed [M-1:0]     sat_val;

   // Delay line: shifts one position per clock; reset discards all history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k < N; k++) begin
            d[k] <= '0;
         end
      end else begin
         d[1] <= bus.x;
         for (int k = 2; k < N; k++) begin
            d[k] <= d[k-1];
         end
      end
   end

   // Full-precision multiply-accumulate. Both operands are sign-extended to
   // the accumulator width first so the multiply is signed and never wraps.
   always_comb begin
      logic signed [ACC_W-1:0] coef_ext;
      logic signed [ACC_W-1:0] samp_ext;
      coef_ext = ACC_W'($signed(COEFFS[0 +: M]));
      samp_ext = ACC_W'(bus.x);
      acc      = coef_ext * samp_ext;
      for (int k = 1; k < N; k++) begin
         coef_ext = ACC_W'($signed(COEFFS[k*M +: M]));
         samp_ext = ACC_W'(d[k]);
         acc      = acc + coef_ext * samp_ext;
      end
   end

   // Drop the Q1.(M-1) fraction bits with an arithmetic shift (floor, no
   // rounding), then clamp into the signed M-bit output range.
   always_comb begin
      scaled = acc >>> (M - 1);
      if (scaled > SAT_MAX) begin
         sat_val = SAT_MAX[M-1:0];
      end else if (scaled < SAT_MIN) begin
         sat_val = SAT_MIN[M-1:0];
      end else begin
         sat_val = scaled[M-1:0];
      end
   end

   // Output register; cleared together with the delay line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.y <= '0;
      end else begin
         bus.y <= sat_val;
      end
   end

endmodule

// File: tb/tb_fir_filter.sv
// Testbench for fir_filter.
// Two instances: the default 16-tap moving average and a copy with every
// coefficient at 127 to exercise saturation. Inputs change 1ns after the
// rising edge and outputs are read at the same point, so each value of y
// read after a step reflects the x applied before that step.
module tb_fir_filter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fir_filter_if #(.M(8)) bus ();
   fir_filter_if #(.M(8)) sat_bus ();

   fir_filter #(.N(16), .M(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   fir_filter #(.N(16), .M(8), .COEFFS({16{8'sd127}})) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (sat_bus)
   );

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Clear both filters with zero inputs, then release reset between edges.
   task automatic do_reset();
      reset    = 1'b0;
      bus.x    = '0;
      sat_bus.x = '0;
      step();
      reset = 1'b1;
   endtask

   // Held reset ignores x; an asynchronous assertion clears y before an edge.
   task automatic test_reset();
      reset = 1'b0;
      bus.x = 8'sd100;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.y !== 8'sd0) begin
            errors++;
            $display("[TB] FAIL reset_hold[%0d]: got %0d, want 0", i, bus.y);
         end
      end
      reset = 1'b1;
      // 100*8/128 = 6.25 -> 6, then 12, then 18
      for (int i = 0; i < 3; i++) begin
         logic signed [7:0] e;
         step();
         e = 8'(6 * (i + 1) + ((i == 2) ? 0 : 0));
         if (i == 1) e = 8'sd12;
         if (i == 2) e = 8'sd18;
         checks++;
         if (bus.y !== e) begin
            errors++;
            $display("[TB] FAIL reset_resume[%0d]: got %0d, want %0d", i, bus.y, e);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.y !== 8'sd0) begin
         errors++;
         $display("[TB] FAIL reset_async: got %0d, want 0", bus.y);
      end
      step();
      reset = 1'b1;
   endtask

   // A single 64 sample produces 64*8/128 = 4 for exactly 16 outputs.
   task automatic test_impulse();
      do_reset();
      bus.x = 8'sd64;
      for (int i = 0; i < 18; i++) begin
         logic signed [7:0] e;
         step();
         bus.x = 8'sd0;
         e = (i < 16) ? 8'sd4 : 8'sd0;
         checks++;
         if (bus.y !== e) begin
            errors++;
            $display("[TB] FAIL impulse[%0d]: got %0d, want %0d", i, bus.y, e);
         end
      end
   endtask

   // Held 127: y = floor((k+1)*1016/128), reaching 127 after 16 samples.
   task automatic test_pos_step();
      do_reset();
      bus.x = 8'sd127;
      for (int i = 0; i < 20; i++) begin
         logic signed [7:0] e;
         int n;
         step();
         n = (i < 16) ? i + 1 : 16;
         e = 8'((n * 1016) / 128);
         checks++;
         if (bus.y !== e) begin
            errors++;
            $display("[TB] FAIL pos_step[%0d]: got %0d, want %0d", i, bus.y, e);
         end
      end
   endtask

   // Held -128 steps down by 8; held -1 floors to -1 rather than 0.
   task automatic test_neg_step();
      do_reset();
      bus.x = -8'sd128;
      for (int i = 0; i < 20; i++) begin
         logic signed [7:0] e;
         int n;
         step();
         n = (i < 16) ? i + 1 : 16;
         e = 8'(-8 * n);
         checks++;
         if (bus.y !== e) begin
            errors++;
            $display("[TB] FAIL neg_step[%0d]: got %0d, want %0d", i, bus.y, e);
         end
      end
      do_reset();
      bus.x = -8'sd1;
      for (int i = 0; i < 16; i++) begin
         step();
         checks++;
         if (bus.y !== -8'sd1) begin
            errors++;
            $display("[TB] FAIL trunc_minus1[%0d]: got %0d, want -1", i, bus.y);
         end
      end
   endtask

   // Coefficients of 127: first output 16129/128 -> 126, then it clamps.
   task automatic test_saturation();
      do_reset();
      sat_bus.x = 8'sd127;
      for (int i = 0; i < 20; i++) begin
         logic signed [7:0] e;
         step();
         e = (i == 0) ? 8'sd126 : 8'sd127;
         checks++;
         if (sat_bus.y !== e) begin
            errors++;
            $display("[TB] FAIL sat_pos[%0d]: got %0d, want %0d", i, sat_bus.y, e);
         end
      end
      do_reset();
      sat_bus.x = -8'sd128;
      for (int i = 0; i < 20; i++) begin
         logic signed [7:0] e;
         step();
         e = (i == 0) ? -8'sd127 : -8'sd128;
         checks++;
         if (sat_bus.y !== e) begin
            errors++;
            $display("[TB] FAIL sat_neg[%0d]: got %0d, want %0d", i, sat_bus.y, e);
         end
      end
   endtask

   // Random stream with a sub-cycle reset pulse; compared against a
   // reference moving-average convolution whose history restarts at the pulse.
   task automatic test_reset_midstream();
      int hist [16];
      do_reset();
      for (int k = 0; k < 16; k++) hist[k] = 0;
      for (int i = 0; i < 40; i++) begin
         logic signed [7:0] s;
         logic signed [7:0] e;
         int sum;
         s = 8'($urandom_range(0, 255));
         bus.x = s;
         if (i == 20) begin
            @(negedge clk);
            reset = 1'b0;
            #1;
            checks++;
            if (bus.y !== 8'sd0) begin
               errors++;
               $display("[TB] FAIL mid_pulse: got %0d, want 0", bus.y);
            end
            #1;
            reset = 1'b1;
            for (int k = 0; k < 16; k++) hist[k] = 0;
         end
         step();
         for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = int'(s);
         sum = 0;
         for (int k = 0; k < 16; k++) sum += 8 * hist[k];
         sum = sum >>> 7;
         if (sum > 127) sum = 127;
         if (sum < -128) sum = -128;
         e = 8'(sum);
         checks++;
         if (bus.y !== e) begin
            errors++;
            $display("[TB] FAIL mid_stream[%0d]: got %0d, want %0d", i, bus.y, e);
         end
      end
   endtask

   initial begin
      bus.x     = '0;
      sat_bus.x = '0;
      test_reset();
      test_impulse();
      test_pos_step();
      test_neg_step();
      test_saturation();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
